// File: rtl/user_mode_pkg.sv
// Shared types and constants for the boot-mode selector.
package user_mode_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    OFFER  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Mode value that selects the guest session (no password).
  localparam int MODE_GUEST = 0;

  // Cycles after reset release during which the synchroniser still holds
  // its reset contents rather than real switch samples.
  localparam int PRIME_CYCLES = 2;

  // Debounce counter width: $clog2 of the window, never less than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/user_mode_select_sync_2ff.sv
// Generic two-flop synchroniser, reset to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability on asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/user_mode_select.sv
// Boot-mode selector: synchronises and debounces the board switches, latches
// them as the session mode, offers it with valid/ack and then freezes it
// until a reselect.
//
// state  | meaning
// SETTLE | waiting for DEBOUNCE_CYCLES stable samples; mode_valid low
// OFFER  | mode latched and valid; waiting for ack
// LOCKED | mode frozen, switches ignored; only reselect leaves
module user_mode_select
  import user_mode_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic              reselect,
  input  logic              ack,
  output logic [NUM_SW-1:0] mode,
  output logic              mode_valid,
  output logic              pw_required,
  output logic              busy
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      PRIME_DONE = 2'(PRIME_CYCLES);
  localparam logic [NUM_SW-1:0] GUEST  = NUM_SW'(MODE_GUEST);

  logic [NUM_SW-1:0] sw_s;
  logic [NUM_SW-1:0] sw_prev_q;
  logic [1:0]        prime_q;
  logic              primed;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_SW-1:0] mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              pw_q, pw_d;
  logic              busy_q, busy_d;

  sync_2ff #(.WIDTH(NUM_SW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sw),
    .q_o (sw_s)
  );

  // The synchroniser output is only trusted once it has been flushed with
  // real samples; until then counting is held off so a stale zero cannot
  // start the debounce window early.
  assign primed = (prime_q == PRIME_DONE);

  // Track the previous synchronised sample and the post-reset flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev_q <= '0;
      prime_q   <= '0;
    end else begin
      sw_prev_q <= sw_s;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      valid_q <= 1'b0;
      pw_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      pw_q    <= pw_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    pw_d    = pw_q;

    case (state_q)
      SETTLE: begin
        valid_d = 1'b0;
        if (reselect || !primed || (sw_s != sw_prev_q)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          mode_d  = sw_s;
          pw_d    = (sw_s != GUEST);
          valid_d = 1'b1;
          state_d = OFFER;
        end else begin
          // Increment only below the terminal count, so it never wraps.
          cnt_d = cnt_q + CW'(1);
        end
      end
      OFFER: begin
        if (reselect) begin
          state_d = SETTLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (ack) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (reselect) begin
          state_d = SETTLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != LOCKED);
  end

  assign mode        = mode_q;
  assign mode_valid  = valid_q;
  assign pw_required = pw_q;
  assign busy        = busy_q;

endmodule

// File: doc/user_mode_select.md
# user_mode_select

Parametrised boot-mode selector that synchronises and debounces a bank of `NUM_SW` board toggle switches and latches their value as the session mode after reset or on request. It offers the mode to downstream consumers (timer speed control, user login) with a valid/ack handshake, then freezes it against switch movement until an explicit reselect. Mode 0 is the guest session; any non-zero mode requires a password.

## Interface
- `NUM_SW`, default 2: number of toggle switches; also the width of `mode`; legal range 1..8.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before latching; legal range ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high. Clears all state immediately on assertion; release is synchronous to `clk`.
- `sw`  in  NUM_SW  raw switch levels; asynchronous to `clk`.
- `reselect`  in  1  single-cycle request to discard the current mode and resample.
- `ack`  in  1  downstream acceptance of the offered mode.
- `mode`  out  NUM_SW  latched switch pattern.
- `mode_valid`  out  1  `mode` is stable and usable.
- `pw_required`  out  1  `mode != 0`; qualified by `mode_valid`.
- `busy`  out  1  high in every state except LOCKED.

## Operation
- `sw` passes through a two-flop synchroniser to give `sw_s`. No other logic uses raw `sw`.
- The FSM has three states: SETTLE, OFFER and LOCKED.
- **SETTLE** (entered from reset):
  - Each cycle, compare `sw_s` with the register `sw_prev`, then update `sw_prev <= sw_s`.
  - On a mismatch, clear `cnt` to 0. On a match, increment `cnt`.
  - When a match occurs with `cnt == DEBOUNCE_CYCLES-1`: `mode <= sw_s`, `pw_required <= |sw_s`, `mode_valid <= 1`, go to OFFER.
  - `mode_valid` is 0 throughout SETTLE.
- **OFFER**:
  - `mode` and `mode_valid` are held.
  - `ack` moves the FSM to LOCKED.
  - `reselect` moves the FSM to SETTLE, with `mode_valid <= 0` and `cnt <= 0`.
  - If `ack` and `reselect` arrive in the same cycle, `reselect` wins.
- **LOCKED**:
  - `mode`, `mode_valid` = 1 and `pw_required` are frozen.
  - Switch changes are ignored; the synchroniser keeps running.
  - `ack` is ignored.
  - `reselect` causes the same transition to SETTLE as in OFFER.
- `reselect` in SETTLE clears `cnt`; the state is unchanged.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES)`. `cnt` saturates and never wraps, so it cannot roll over and falsely latch.
- `mode` keeps its last value while in SETTLE. Consumers must gate on `mode_valid`.

## Timing
- **Reset values:** `mode` = 0, `mode_valid` = 0, `pw_required` = 0, `busy` = 1; state = SETTLE; `cnt`, `sw_prev` and synchroniser flops = 0.
- **Reset mid-operation:** asserting `rst` in any state returns all outputs to their reset values asynchronously. Any handshake in progress is abandoned.
- All outputs are registered; there is no combinational path from any input to any output.
- **Latch latency with `sw` stable from reset release:**
  - If `sw` equals the post-reset `sw_prev` value of 0, `mode_valid` rises at cycle 2 + DEBOUNCE_CYCLES after the first clock edge following release.
  - If `sw` is non-zero, one extra cycle is added for the initial mismatch.
- **Bounce:** a single-cycle glitch on `sw_s` restarts the full `DEBOUNCE_CYCLES` window.
- **Reselect latency:** `mode_valid` falls on the edge after `reselect` is sampled. The earliest relatch is `DEBOUNCE_CYCLES` cycles after that.
- **Handshake:** `ack` is sampled only while in OFFER. `busy` falls on the edge on which LOCKED is entered.

## Structure
- **Package `user_mode_pkg`:**
  - state enum `{SETTLE, OFFER, LOCKED}`;
  - `MODE_GUEST` = 0;
  - a function computing the `cnt` width.
- **Sub-module `sync_2ff`:** parametrised by width and reusable elsewhere in the design; it contains only the two-flop synchroniser, reset to 0.
- FSM, debounce counter and output registers live in the top module.

## Test plan
Parameters for all scenarios: `NUM_SW`=2, `DEBOUNCE_CYCLES`=4.
- **Guest boot:** `sw`=2'b00 held through reset release → `mode_valid`=1 at cycle 6 after release, `mode`=0, `pw_required`=0; `ack` → `busy`=0.
- **Password boot:** `sw`=2'b10 held → `mode_valid`=1 at cycle 7, `mode`=2'b10, `pw_required`=1.
- **Bounce:** `sw` toggles 01→00→01 with 1-cycle and 2-cycle glitches → no latch until 4 consecutive stable `sw_s` samples; final `mode`=2'b01.
- **Lock then reselect:** in LOCKED, change `sw` to 2'b11 → `mode` stays the same. Pulse `reselect` → `mode_valid`=0 next cycle; after the debounce window, `mode`=2'b11 and `busy`=1 until `ack`.
- **Simultaneous events:** `ack` and `reselect` in the same OFFER cycle → next state SETTLE, `mode_valid`=0, `busy`=1.
- **Async reset:** assert `rst` between clock edges while in LOCKED → all outputs 0 (`busy`=1) before the next edge; normal relatch follows release.
